// File: rtl/msk_rnd_pkg.sv
// ============================================================================
// Module   : msk_rnd_pkg
// Brief    : Shared types and constants for the masked-gadget randomness source
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package msk_rnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_WARM = 2'd2,
        ST_RUN  = 2'd3
    } rnd_state_e;

    // Replaces w when a lane would otherwise be stuck in the all-zero state
    localparam logic [31:0] c_zero_fix = 32'h0000_0001;

    localparam int c_xs_shl_t = 11;
    localparam int c_xs_shr_w = 19;
    localparam int c_xs_shr_t = 8;

    function automatic int lanes(input int rnd_w);
        return (rnd_w + 31) / 32;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msk_xorshift128_lane.sv
// ============================================================================
// Module   : msk_xorshift128_lane
// Brief    : One xorshift128 lane with word-serial load and zero-state guard
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msk_xorshift128_lane
    import msk_rnd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic        load,
    input  logic [1:0]  load_sel,
    input  logic [31:0] load_data,
    input  logic        fix_zero,
    output logic [31:0] w
);

    logic [31:0] x_q, y_q, z_q, w_q;
    logic [31:0] x_d, y_d, z_d, w_d;
    logic [31:0] w_t;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        w_d = w_q;
        w_t = x_q ^ (x_q << c_xs_shl_t);
        if (load) begin
            case (load_sel)
                2'd0:    x_d = load_data;
                2'd1:    y_d = load_data;
                2'd2:    z_d = load_data;
                default: w_d = load_data;
            endcase
        end else if (step) begin
            x_d = y_q;
            y_d = z_q;
            z_d = w_q;
            w_d = w_q ^ (w_q >> c_xs_shr_w) ^ w_t ^ (w_t >> c_xs_shr_t);
        end
        // Guard looks at the post-load words so the final seed word is included
        if (fix_zero && ((x_d | y_d | z_d | w_d) == 32'd0)) begin
            w_d = c_zero_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            w_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            w_q <= w_d;
        end
    end

    assign w = w_q;

endmodule

`default_nettype wire

// File: rtl/msk_rnd_gen.sv
// ============================================================================
// Module   : msk_rnd_gen
// Brief    : Seeded xorshift128 randomness source feeding HPC2 gadget rnd inputs.
//            MSK_RND_ZERO_EN (debug only) forces rnd to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msk_rnd_gen
    import msk_rnd_pkg::*;
#(
    parameter int d        = 2,
    parameter int NGADGETS = 1,
    parameter int WARMUP   = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [31:0]                         seed_data,
    input  logic                                seed_valid,
    output logic                                seed_ready,
    output logic [NGADGETS*d*(d-1)/2-1:0]       rnd,
    output logic                                rnd_valid,
    input  logic                                rnd_ready
);

    localparam int RND_W = NGADGETS * d * (d - 1) / 2;
    localparam int K     = lanes(RND_W);
    localparam int NSEED = 4 * K;
    localparam int CNT_W = $clog2(NSEED) + 1;

    rnd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       warm_q, warm_d;

    logic             w_seed_hs;
    logic             w_step;
    logic             w_fix_zero;
    logic [CNT_W-1:0] w_wr_idx;
    logic [K*32-1:0]  w_lanes;

    assign seed_ready = (state_q != ST_WARM);
    assign rnd_valid  = (state_q == ST_RUN);
    assign w_seed_hs  = seed_valid && seed_ready;
    assign w_wr_idx   = (state_q == ST_SEED) ? cnt_q : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        warm_d     = warm_q;
        w_step     = 1'b0;
        w_fix_zero = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_seed_hs) begin
                    state_d = ST_SEED;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SEED: begin
                if (w_seed_hs) begin
                    if (cnt_q == CNT_W'(NSEED - 1)) begin
                        state_d    = ST_WARM;
                        cnt_d      = '0;
                        w_fix_zero = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_WARM: begin
                w_step = 1'b1;
                if (warm_q == 8'(WARMUP - 1)) begin
                    state_d = ST_RUN;
                    warm_d  = '0;
                end else begin
                    warm_d = warm_q + 8'd1;
                end
            end
            ST_RUN: begin
                // A reseed takes priority over the consumer; the lanes hold
                if (w_seed_hs) begin
                    state_d = ST_SEED;
                    cnt_d   = CNT_W'(1);
                end else begin
                    w_step = rnd_ready;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_lane
        logic w_load;
        assign w_load = w_seed_hs && (int'(w_wr_idx >> 2) == gi);

        msk_xorshift128_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .step      (w_step),
            .load      (w_load),
            .load_sel  (w_wr_idx[1:0]),
            .load_data (seed_data),
            .fix_zero  (w_fix_zero),
            .w         (w_lanes[gi*32 +: 32])
        );
    end

`ifdef MSK_RND_ZERO_EN
    logic w_unused_lanes;
    assign w_unused_lanes = ^w_lanes;
    assign rnd = '0;
`else
    assign rnd = w_lanes[RND_W-1:0];
    if (K * 32 > RND_W) begin : g_trim
        logic w_unused_hi;
        assign w_unused_hi = ^w_lanes[K*32-1:RND_W];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_msk_rnd_gen.sv
// ============================================================================
// Module   : tb_msk_rnd_gen
// Brief    : Directed scoreboard bench for msk_rnd_gen (d=9, two lanes)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msk_rnd_gen;

    localparam int P_D      = 9;
    localparam int P_NG     = 1;
    localparam int P_WARMUP = 1;
    localparam int RND_W    = 36;
    localparam int NSEED    = 8;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic [31:0]       seed_data  = '0;
    logic              seed_valid = 1'b0;
    logic              rnd_ready  = 1'b0;
    logic              seed_ready;
    logic              rnd_valid;
    logic [RND_W-1:0]  rnd;

    int checks = 0;
    int errors = 0;

    logic [31:0]      m [2][4];
    logic [31:0]      words [NSEED];
    logic [31:0]      ref_w [4] = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};
    logic [RND_W-1:0] exp_q [$];
    logic [RND_W-1:0] prev;

    msk_rnd_gen #(.d(P_D), .NGADGETS(P_NG), .WARMUP(P_WARMUP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_data  (seed_data),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .rnd        (rnd),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready)
    );

    always #5 clk = ~clk;

    function automatic void m_clear();
        for (int l = 0; l < 2; l++)
            for (int j = 0; j < 4; j++) m[l][j] = '0;
    endfunction

    function automatic void m_step();
        logic [31:0] t;
        for (int l = 0; l < 2; l++) begin
            t = m[l][0] ^ (m[l][0] << 11);
            m[l][0] = m[l][1];
            m[l][1] = m[l][2];
            m[l][2] = m[l][3];
            m[l][3] = m[l][3] ^ (m[l][3] >> 19) ^ t ^ (t >> 8);
        end
    endfunction

    function automatic void m_guard();
        for (int l = 0; l < 2; l++)
            if ((m[l][0] | m[l][1] | m[l][2] | m[l][3]) == 32'd0) m[l][3] = 32'd1;
    endfunction

    function automatic logic [RND_W-1:0] m_rnd();
        logic [63:0] c;
        c = {m[1][3], m[0][3]};
        return c[RND_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [RND_W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=none", tag, rnd);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(rnd), 64'(e));
        end
    endtask

    task automatic send_words(input int first);
        for (int n = first; n < NSEED; n++) begin
            seed_valid = 1'b1;
            seed_data  = words[n];
            chk("seed_ready_seed", 64'(seed_ready), 64'd1);
            @(posedge clk);
            m[n / 4][n % 4] = words[n];
            if (n == NSEED - 1) m_guard();
            @(negedge clk);
            chk("rnd_valid_seed", 64'(rnd_valid), 64'd0);
        end
        seed_valid = 1'b0;
    endtask

    task automatic warm_up();
        seed_valid = 1'b1;
        seed_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < P_WARMUP; i++) begin
            chk("seed_ready_warm", 64'(seed_ready), 64'd0);
            chk("rnd_valid_warm", 64'(rnd_valid), 64'd0);
            m_step();
            if (i == P_WARMUP - 1) exp_q.push_back(m_rnd());
            @(negedge clk);
        end
        seed_valid = 1'b0;
        chk("rnd_valid_run", 64'(rnd_valid), 64'd1);
        pop_check("rnd_first");
    endtask

    task automatic run_cycle(input logic r, input string tag);
        rnd_ready = r;
        chk("rnd_valid_cycle", 64'(rnd_valid), 64'd1);
        if (r) m_step();
        exp_q.push_back(m_rnd());
        @(negedge clk);
        rnd_ready = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        m_clear();
        repeat (2) @(negedge clk);
        chk("rst_rnd", 64'(rnd), 64'd0);
        chk("rst_rnd_valid", 64'(rnd_valid), 64'd0);
        chk("rst_seed_ready", 64'(seed_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < NSEED; n++) words[n] = ref_w[n % 4];
        send_words(0);
        warm_up();
        chk("rnd_reference", 64'(rnd), 64'h0000_000A_DCA3_45EA);

        run_cycle(1'b1, "rdy_1");
        run_cycle(1'b0, "rdy_0_hold");
        run_cycle(1'b1, "rdy_1_again");
        repeat (3) run_cycle(1'b1, "rdy_burst");

        // Reseed with all-zero words while the consumer also asks for a step
        prev = rnd;
        chk("valid_at_reseed", 64'(rnd_valid), 64'd1);
        for (int n = 0; n < NSEED; n++) words[n] = '0;
        seed_valid = 1'b1;
        seed_data  = '0;
        rnd_ready  = 1'b1;
        @(posedge clk);
        m[0][0] = '0;
        @(negedge clk);
        chk("reseed_valid_drop", 64'(rnd_valid), 64'd0);
        chk("reseed_no_step", 64'(rnd), 64'(prev));
        send_words(1);
        warm_up();
        rnd_ready = 1'b0;
        chk("zero_guard_value", 64'(rnd), 64'h0000_0001_0000_0001);
        run_cycle(1'b1, "zero_guard_step");

        // Abort a partial seed with an asynchronous reset
        for (int n = 0; n < NSEED; n++) words[n] = ref_w[n % 4];
        for (int n = 0; n < 2; n++) begin
            seed_valid = 1'b1;
            seed_data  = words[n];
            @(negedge clk);
        end
        seed_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rnd", 64'(rnd), 64'd0);
        chk("rst_mid_rnd_valid", 64'(rnd_valid), 64'd0);
        chk("rst_mid_seed_ready", 64'(seed_ready), 64'd1);
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_words(0);
        warm_up();
        chk("rnd_reference_again", 64'(rnd), 64'h0000_000A_DCA3_45EA);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/msk_rnd_gen.md
# msk_rnd_gen

Randomness producer for the masked-gadget datapath. It generates the fresh random bits that the HPC2 masked AND gadgets consume on their `rnd` inputs, sized `NGADGETS*d*(d-1)/2` bits per cycle. After a serial seeding handshake and a warm-up phase, it delivers one fresh randomness vector per accepted consumer cycle. It sits between the top-level seed/TRNG interface and the gadget array of each masked core.

## Interface
- `d`, default 2: masking order + 1 (number of shares); must match the consuming gadgets.
- `NGADGETS`, default 1: number of gadgets fed in parallel.
- `WARMUP`, default 16: discarded generator steps after seeding; legal range 1..255.
- Derived localparams:
  - `RND_W = NGADGETS*d*(d-1)/2`
  - `K = ceil(RND_W/32)` (number of lanes)
  - `NSEED = 4*K` (number of seed words)

Ports (the clock is `clk`; reset is `rst_n`, asynchronous, active-low; these are already decided):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seed_data` in 32: seed word.
- `seed_valid` in 1: `seed_data` is valid.
- `seed_ready` out 1: block accepts a seed word this cycle.
- `rnd` out `RND_W`: randomness vector for the gadgets.
- `rnd_valid` out 1: `rnd` is fresh and usable.
- `rnd_ready` in 1: the consumer takes `rnd` this cycle; the generator steps.

## Operation
- `K` xorshift128 lanes, each with 32-bit words x, y, z, w. One step:
  - t = x ^ (x<<11)
  - x=y; y=z; z=w
  - w = w ^ (w>>19) ^ t ^ (t>>8)
  - All shifts are logical and truncated to 32 bits.
- `rnd` = {lane K-1 w, …, lane 0 w}[RND_W-1:0]. Any upper bits of lane K-1 are dropped.
- FSM states: IDLE, SEED, WARM, RUN.
  - IDLE: `seed_ready`=1. A seed handshake writes word 0 and moves to SEED (or to WARM if NSEED=1 is impossible; NSEED≥4 always).
  - SEED: `seed_ready`=1. Word n goes to lane n/4, register x/y/z/w for n%4 = 0/1/2/3. After word NSEED-1 is accepted, go to WARM. The word counter resets to 0.
  - WARM: `seed_ready`=0. All lanes step every cycle for exactly WARMUP cycles, then go to RUN.
  - RUN: `rnd_valid`=1 and `seed_ready`=1. All lanes step in every cycle with `rnd_ready`=1 and hold otherwise.
- Reseed during RUN: a seed handshake writes word 0, moves to SEED, and drops `rnd_valid` from the next cycle.
  - If `rnd_ready` and a seed handshake coincide, the seed write wins. No step occurs that cycle, but the `rnd` value presented that cycle is still valid.
- Zero-state guard: if a lane's four words are all zero at SEED exit, its w is forced to 32'h0000_0001 on the same edge.
- `seed_valid` in WARM is ignored and not acknowledged.
- `rnd_ready` outside RUN is ignored.

## Timing
- Reset values:
  - state IDLE, word counter 0, warm-up counter 0
  - all lane registers 0
  - `rnd`=0, `rnd_valid`=0, `seed_ready`=1
- `rnd` and `rnd_valid` are driven directly from registers; there is no combinational path from `rnd_ready`.
- Seeding takes exactly NSEED handshake cycles. Back-to-back words are accepted at 1 per cycle.
- Latency:
  - The last seed handshake is at edge E.
  - WARM spans edges E+1 … E+WARMUP.
  - `rnd_valid`=1 after edge E+WARMUP.
- Throughput: one new `rnd` vector per cycle when `rnd_ready` is held high. After an edge with `rnd_ready`=1, the new `rnd` is visible.
- Reset asserted mid-operation immediately returns every output to its reset value. Any partial seed is discarded.

## Configuration
- `MSK_RND_ZERO_EN`:
  - Defined: `rnd` is forced to all-zero. The FSM, handshakes and lane stepping are unchanged. This is for functional debug of unmasked-equivalent behaviour only and must never be defined in side-channel builds.
  - Undefined: normal generator output.

## Structure
- Package `msk_rnd_pkg` holds:
  - the FSM state enum (IDLE/SEED/WARM/RUN)
  - `function lanes(rnd_w)` returning ceil(rnd_w/32)
  - `localparam` zero-guard constant 32'h0000_0001
  - the xorshift shift constants 11/19/8
- Sub-module `msk_xorshift128_lane`:
  - Inputs: `clk`, `rst_n`, `step`, `load`, `load_sel[1:0]`, `load_data[31:0]`, `fix_zero`.
  - Output: `w[31:0]`.
  - The top instantiates it `K` times in a generate loop.

## Test plan
- Reset, then d=2, NGADGETS=1, WARMUP=1. Seed x=123456789, y=362436069, z=521288629, w=88675123 -> `rnd_valid` rises 1 cycle after the last seed word, `rnd`=32'hDCA345EA (1 bit: bit 0 = 0).
- Same seeding with d=9, NGADGETS=1 (RND_W=36, K=2), lane 1 seeded identically to lane 0 -> `rnd`[35:32] = 4'hA, `rnd`[31:0] = 32'hDCA345EA, and NSEED=8 handshakes are required.
- All-zero seed, WARMUP=1 -> lane w forced to 1 at SEED exit; after 1 step the output is nonzero and equals the reference-model value.
- RUN with `rnd_ready` toggling 1,0,1 -> `rnd` changes only after the cycles where `rnd_ready`=1 and holds otherwise. Compare against the software model.
- Reseed in RUN with `rnd_ready`=1 in the same cycle -> no step, `rnd_valid`=0 next cycle, re-enters RUN exactly NSEED-1+WARMUP cycles later.
- `rst_n` pulsed low after 2 of 4 seed words -> all outputs at reset values, and full reseeding reproduces the first test's value.
